// File: rtl/tpm_fifo_sts_ctrl.sv
// rtl/tpm_fifo_sts_ctrl.sv - TPM FIFO-interface TPM_STS/TPM_DATA_FIFO sequencer with shared command/response buffer
// Optional feature: TPM_STS_RETRY_EN enables responseRetry (re-read of the response).
module tpm_fifo_sts_ctrl #(
    parameter int BUF_BYTES = 2048,
    parameter int AW        = $clog2(BUF_BYTES)
) (
    input  logic          clk_i,
    input  logic          rst_n_i,
    input  logic          host_ok_i,
    input  logic          sts_wr_i,
    input  logic          fifo_wr_i,
    input  logic          fifo_rd_i,
    input  logic [7:0]    host_data_i,
    output logic [7:0]    fifo_data_o,
    output logic [7:0]    sts_o,
    output logic [15:0]   burst_count_o,
    input  logic          abort_i,
    output logic          cmd_start_o,
    output logic [AW:0]   cmd_len_o,
    input  logic [AW-1:0] core_addr_i,
    input  logic          core_we_i,
    input  logic [7:0]    core_wdata_i,
    output logic [7:0]    core_rdata_o,
    input  logic          core_done_i,
    input  logic [AW:0]   core_rsp_len_i,
    output logic          data_avail_o
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READY,
        ST_RECEPTION,
        ST_EXECUTION,
        ST_COMPLETION
    } state_e;

    localparam logic [AW:0] BUF_LEN  = (AW+1)'(BUF_BYTES);
    localparam logic [AW:0] HDR_LEN  = (AW+1)'(6);
    localparam logic [AW:0] SIZE_LO  = (AW+1)'(2);

    state_e       state_q, state_d;
    logic [AW:0]  wr_ptr_q, wr_ptr_d;
    logic [AW:0]  rd_ptr_q, rd_ptr_d;
    logic [AW:0]  cmd_len_q, cmd_len_d;
    logic [AW:0]  rsp_len_q, rsp_len_d;
    logic [31:0]  cmd_size_q, cmd_size_d;
    logic         cmd_start_q, cmd_start_d;
    logic         data_avail_q, data_avail_d;
    logic [7:0]   fifo_data_q, fifo_data_d;
    logic [7:0]   core_rdata_q;

    logic [7:0]   mem [BUF_BYTES];

    logic         host_act, sts_act, cmd_rdy, tpm_go, fifo_ok;
    logic         in_rx, expect_w, avail_w;
    logic         host_we, core_we;
    logic         mem_we;
    logic [AW-1:0] mem_addr;
    logic [7:0]   mem_wdata;
    logic [AW:0]  burst_w;

    assign host_act = host_ok_i & ~abort_i;
    assign sts_act  = host_act & sts_wr_i;
    assign cmd_rdy  = sts_act & host_data_i[6];
    assign tpm_go   = sts_act & ~host_data_i[6] & host_data_i[5];
    assign fifo_ok  = host_act & ~sts_wr_i;

    assign in_rx    = (state_q == ST_READY) || (state_q == ST_RECEPTION);
    assign expect_w = in_rx && ((wr_ptr_q < HDR_LEN) ||
                                ({{(31-AW){1'b0}}, wr_ptr_q} < cmd_size_q));
    assign avail_w  = (state_q == ST_COMPLETION) && (rd_ptr_q < rsp_len_q);

    assign host_we  = fifo_ok & fifo_wr_i & expect_w & (wr_ptr_q != BUF_LEN);
    assign core_we  = (state_q == ST_EXECUTION) & core_we_i & ~abort_i;

    // States are exclusive, so host and core share one write port.
    assign mem_we    = host_we | core_we;
    assign mem_addr  = host_we ? wr_ptr_q[AW-1:0] : core_addr_i;
    assign mem_wdata = host_we ? host_data_i : core_wdata_i;

    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        cmd_len_d    = cmd_len_q;
        rsp_len_d    = rsp_len_q;
        cmd_size_d   = cmd_size_q;
        cmd_start_d  = 1'b0;
        data_avail_d = 1'b0;
        if (abort_i) begin
            state_d    = ST_IDLE;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            cmd_size_d = '0;
        end else begin
            if (cmd_rdy && state_q != ST_EXECUTION) begin
                state_d    = ST_READY;
                wr_ptr_d   = '0;
                rd_ptr_d   = '0;
                cmd_size_d = '0;
            end else if (tpm_go && state_q == ST_RECEPTION && !expect_w) begin
                state_d     = ST_EXECUTION;
                cmd_len_d   = wr_ptr_q;
                cmd_start_d = 1'b1;
`ifdef TPM_STS_RETRY_EN
            end else if (sts_act && host_data_i[1] && state_q == ST_COMPLETION) begin
                rd_ptr_d = '0;
`endif
            end else begin
                if (host_we) begin
                    state_d  = ST_RECEPTION;
                    wr_ptr_d = wr_ptr_q + 1'b1;
                    // Bytes 2..5 shift in big-endian; complete once the 6th byte lands.
                    if (wr_ptr_q >= SIZE_LO && wr_ptr_q < HDR_LEN)
                        cmd_size_d = {cmd_size_q[23:0], host_data_i};
                end
                if (fifo_ok && fifo_rd_i && avail_w)
                    rd_ptr_d = rd_ptr_q + 1'b1;
            end
            if (state_q == ST_EXECUTION && core_done_i) begin
                state_d      = ST_COMPLETION;
                rsp_len_d    = core_rsp_len_i;
                rd_ptr_d     = '0;
                data_avail_d = 1'b1;
            end
        end
        // Prefetch from the next read pointer so the byte is ready when dataAvail rises.
        if (state_d == ST_COMPLETION && rd_ptr_d < rsp_len_d)
            fifo_data_d = mem[rd_ptr_d[AW-1:0]];
        else
            fifo_data_d = 8'hFF;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q      <= ST_IDLE;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            cmd_len_q    <= '0;
            rsp_len_q    <= '0;
            cmd_size_q   <= '0;
            cmd_start_q  <= 1'b0;
            data_avail_q <= 1'b0;
            fifo_data_q  <= 8'hFF;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            cmd_len_q    <= cmd_len_d;
            rsp_len_q    <= rsp_len_d;
            cmd_size_q   <= cmd_size_d;
            cmd_start_q  <= cmd_start_d;
            data_avail_q <= data_avail_d;
            fifo_data_q  <= fifo_data_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (mem_we)
            mem[mem_addr] <= mem_wdata;
        core_rdata_q <= mem[core_addr_i];
    end

    always_comb begin
        case (state_q)
            ST_READY, ST_RECEPTION: burst_w = BUF_LEN - wr_ptr_q;
            ST_COMPLETION:          burst_w = rsp_len_q - rd_ptr_q;
            default:                burst_w = '0;
        endcase
    end

    assign sts_o         = {1'b1, state_q == ST_READY, 1'b0, avail_w, expect_w, 1'b1, 2'b00};
    assign burst_count_o = 16'(burst_w);
    assign fifo_data_o   = fifo_data_q;
    assign cmd_start_o   = cmd_start_q;
    assign cmd_len_o     = cmd_len_q;
    assign core_rdata_o  = core_rdata_q;
    assign data_avail_o  = data_avail_q;

endmodule
